// File: rtl/instruction_cycle_sequencer.sv
// Fetch/latch/execute/commit sequencer with debug halt, single-step, breakpoint stop
// and a sticky fetch-timeout fault. Strobes are decoded from the state register only.
module instruction_cycle_sequencer #(
    parameter int unsigned TIMEOUT = 15,
    parameter int unsigned CNT_W   = 4
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       MEM_READY,
    input  logic       EXEC_BUSY,
    input  logic       HALT_REQ,
    input  logic       STEP,
    input  logic       RESUME,
    input  logic       BKP_HIT,
    output logic       FETCH_REQ,
    output logic       EXECUTE,
    output logic       PC_INC,
    output logic       HALTED,
    output logic       STEP_DONE,
    output logic       FAULT,
    output logic [2:0] STATE
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_LATCH  = 3'd2,
        S_EXEC   = 3'd3,
        S_COMMIT = 3'd4,
        S_HALT   = 3'd5,
        S_FAULT  = 3'd6
    } state_t;

    localparam logic [CNT_W-1:0] LP_TMO = CNT_W'(TIMEOUT);

    state_t           r_state, w_next;
    logic [CNT_W-1:0] r_cnt, w_cnt;
    logic             r_step, w_step;
    logic             r_pend, w_pend;
    logic             r_step_done, w_step_done;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_step      <= 1'b0;
            r_pend      <= 1'b0;
            r_step_done <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_cnt       <= w_cnt;
            r_step      <= w_step;
            r_pend      <= w_pend;
            r_step_done <= w_step_done;
        end
    end

    // The wait counter is zero outside FETCH, so every FETCH entry starts from zero.
    always_comb begin
        w_next      = r_state;
        w_cnt       = '0;
        w_step      = r_step;
        w_pend      = r_pend;
        w_step_done = 1'b0;
        case (r_state)
            S_IDLE:   w_next = HALT_REQ ? S_HALT : S_FETCH;
            S_FETCH: begin
                if (HALT_REQ) w_pend = 1'b1;
                if (MEM_READY)            w_next = S_LATCH;
                else if (r_cnt == LP_TMO) w_next = S_FAULT;
                else                      w_cnt  = r_cnt + 1'b1;
            end
            S_LATCH: begin
                if (HALT_REQ) w_pend = 1'b1;
                w_next = S_EXEC;
            end
            S_EXEC: begin
                if (HALT_REQ) w_pend = 1'b1;
                if (!EXEC_BUSY) w_next = S_COMMIT;
            end
            S_COMMIT: begin
                if (r_pend || HALT_REQ || BKP_HIT || r_step) begin
                    w_next      = S_HALT;
                    w_step_done = r_step;
                    w_step      = 1'b0;
                end else begin
                    w_next = S_FETCH;
                end
            end
            S_HALT: begin
                if (!HALT_REQ) begin
                    if (RESUME) begin
                        w_next = S_FETCH;
                        w_step = 1'b0;
                    end else if (STEP) begin
                        w_next = S_FETCH;
                        w_step = 1'b1;
                    end
                end
            end
            S_FAULT:  w_next = S_FAULT;
            default:  w_next = S_IDLE;
        endcase
        if (w_next == S_HALT) w_pend = 1'b0;
    end

    assign FETCH_REQ = (r_state == S_FETCH);
    assign EXECUTE   = (r_state == S_LATCH);
    assign PC_INC    = (r_state == S_COMMIT);
    assign HALTED    = (r_state == S_HALT);
    assign FAULT     = (r_state == S_FAULT);
    assign STEP_DONE = r_step_done;
    assign STATE     = r_state;

endmodule

// File: tb/tb_instruction_cycle_sequencer.sv
// Self-checking bench: directed vector table, fetch-timeout sequences and a
// randomized run compared against a phase-based behavioural model.
module tb_instruction_cycle_sequencer;

    localparam int unsigned TMO = 15;

    logic       CLK = 1'b0;
    logic       RESET, MEM_READY, EXEC_BUSY, HALT_REQ, STEP, RESUME, BKP_HIT;
    logic       FETCH_REQ, EXECUTE, PC_INC, HALTED, STEP_DONE, FAULT;
    logic [2:0] STATE;

    int n_vec = 0;
    int n_err = 0;

    instruction_cycle_sequencer #(.TIMEOUT(TMO), .CNT_W(4)) dut (
        .CLK(CLK), .RESET(RESET), .MEM_READY(MEM_READY), .EXEC_BUSY(EXEC_BUSY),
        .HALT_REQ(HALT_REQ), .STEP(STEP), .RESUME(RESUME), .BKP_HIT(BKP_HIT),
        .FETCH_REQ(FETCH_REQ), .EXECUTE(EXECUTE), .PC_INC(PC_INC), .HALTED(HALTED),
        .STEP_DONE(STEP_DONE), .FAULT(FAULT), .STATE(STATE)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [6:0] in;   // {rst, ready, busy, hreq, step, resume, bkp}
        logic [2:0] st;
        logic [5:0] o;    // {fetch_req, execute, pc_inc, halted, step_done, fault}
    } vec_t;

    function automatic vec_t mk(input logic [6:0] in, input logic [2:0] st, input logic [5:0] o);
        vec_t v;
        v.in = in; v.st = st; v.o = o;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [6:0] in);
        {RESET, MEM_READY, EXEC_BUSY, HALT_REQ, STEP, RESUME, BKP_HIT} = in;
    endtask

    function automatic logic [8:0] dut_out();
        return {STATE, FETCH_REQ, EXECUTE, PC_INC, HALTED, STEP_DONE, FAULT};
    endfunction

    task automatic do_reset();
        drive(7'b1000000);
        repeat (2) @(negedge CLK);
        RESET = 1'b0;
    endtask

    // Count FETCH cycles; MEM_READY stays low for n_low of them, then takes rdy_after.
    task automatic fetch_wait(input string name, input int n_low, input logic rdy_after,
                              input int exp_fetch, input int exp_state);
        int fetches;
        do_reset();
        @(negedge CLK);
        fetches = 0;
        for (int i = 0; i < 40; i++) begin
            if (STATE != 3'd1) break;
            fetches++;
            MEM_READY = (fetches > n_low) ? rdy_after : 1'b0;
            @(negedge CLK);
        end
        check({name, "_fetch_cycles"}, fetches, exp_fetch);
        check({name, "_state"}, STATE, exp_state);
        check({name, "_fault"}, FAULT, exp_state == 6);
        check({name, "_execute"}, EXECUTE, exp_state == 2);
        MEM_READY = 1'b1;
        @(negedge CLK);
        check({name, "_single_execute"}, EXECUTE, 0);
    endtask

    // Behavioural model: mode 0 idle, 1 running, 2 halted, 3 faulted;
    // while running, pos is the cycle index inside the instruction (0..3).
    int m_mode, m_pos, m_wait;
    bit m_pend, m_step, m_sdone;

    function automatic logic [8:0] model_out();
        logic [2:0] st;
        bit run;
        run = (m_mode == 1);
        st  = (m_mode == 0) ? 3'd0 : run ? 3'(1 + m_pos) : (m_mode == 2) ? 3'd5 : 3'd6;
        return {st, run && m_pos == 0, run && m_pos == 1, run && m_pos == 3,
                m_mode == 2, m_sdone, m_mode == 3};
    endfunction

    task automatic model_step(input logic [6:0] in);
        bit rst, rdy, busy, hreq, stp, res, bkp;
        {rst, rdy, busy, hreq, stp, res, bkp} = in;
        if (rst) begin
            m_mode = 0; m_pos = 0; m_wait = 0; m_pend = 0; m_step = 0; m_sdone = 0;
            return;
        end
        m_sdone = 0;
        case (m_mode)
            0: if (hreq) begin m_mode = 2; m_pend = 0; end
               else begin m_mode = 1; m_pos = 0; m_wait = 0; end
            1: begin
                if (hreq && m_pos < 3) m_pend = 1;
                if (m_pos == 0) begin
                    if (rdy) m_pos = 1;
                    else if (m_wait == TMO) m_mode = 3;
                    else m_wait++;
                end else if (m_pos == 1) m_pos = 2;
                else if (m_pos == 2) begin
                    if (!busy) m_pos = 3;
                end else begin
                    if (m_pend || hreq || bkp || m_step) begin
                        m_mode = 2; m_sdone = m_step; m_step = 0; m_pend = 0;
                    end else begin
                        m_pos = 0; m_wait = 0;
                    end
                end
            end
            2: if (!hreq && (res || stp)) begin
                m_mode = 1; m_pos = 0; m_wait = 0; m_step = !res;
            end
            default: ;
        endcase
    endtask

    vec_t tbl[30];

    initial begin
        tbl[0]  = mk(7'b1000000, 3'd0, 6'b000000);
        tbl[1]  = mk(7'b1000000, 3'd0, 6'b000000);
        tbl[2]  = mk(7'b0100000, 3'd1, 6'b100000);
        tbl[3]  = mk(7'b0100000, 3'd2, 6'b010000);
        tbl[4]  = mk(7'b0000000, 3'd3, 6'b000000);
        tbl[5]  = mk(7'b0000000, 3'd4, 6'b001000);
        tbl[6]  = mk(7'b0000000, 3'd1, 6'b100000);
        tbl[7]  = mk(7'b0101000, 3'd2, 6'b010000);
        tbl[8]  = mk(7'b0000000, 3'd3, 6'b000000);
        tbl[9]  = mk(7'b0010000, 3'd3, 6'b000000);
        tbl[10] = mk(7'b0000000, 3'd4, 6'b001000);
        tbl[11] = mk(7'b0000000, 3'd5, 6'b000100);
        tbl[12] = mk(7'b0000100, 3'd1, 6'b100000);
        tbl[13] = mk(7'b0100000, 3'd2, 6'b010000);
        tbl[14] = mk(7'b0000000, 3'd3, 6'b000000);
        tbl[15] = mk(7'b0000000, 3'd4, 6'b001000);
        tbl[16] = mk(7'b0000000, 3'd5, 6'b000110);
        tbl[17] = mk(7'b0000000, 3'd5, 6'b000100);
        tbl[18] = mk(7'b0000110, 3'd1, 6'b100000);
        tbl[19] = mk(7'b0100000, 3'd2, 6'b010000);
        tbl[20] = mk(7'b0000000, 3'd3, 6'b000000);
        tbl[21] = mk(7'b0000000, 3'd4, 6'b001000);
        tbl[22] = mk(7'b0000001, 3'd5, 6'b000100);
        tbl[23] = mk(7'b0001010, 3'd5, 6'b000100);
        tbl[24] = mk(7'b0000010, 3'd1, 6'b100000);
        tbl[25] = mk(7'b0100000, 3'd2, 6'b010000);
        tbl[26] = mk(7'b1000000, 3'd0, 6'b000000);
        tbl[27] = mk(7'b0001000, 3'd5, 6'b000100);
        tbl[28] = mk(7'b1000000, 3'd0, 6'b000000);
        tbl[29] = mk(7'b0000000, 3'd1, 6'b100000);

        for (int i = 0; i < 30; i++) begin
            drive(tbl[i].in);
            @(negedge CLK);
            check($sformatf("table[%0d]", i), dut_out(), {tbl[i].st, tbl[i].o});
        end

        fetch_wait("wait5", 5, 1'b1, 6, 2);
        fetch_wait("timeout", 16, 1'b0, 16, 6);
        fetch_wait("ready16", 15, 1'b1, 16, 2);

        // Fault is sticky against every input until reset.
        fetch_wait("timeout2", 16, 1'b0, 16, 6);
        drive(7'b0111111);
        repeat (3) @(negedge CLK);
        check("fault_sticky", dut_out(), {3'd6, 6'b000001});
        drive(7'b1000000);
        @(negedge CLK);
        check("fault_reset", dut_out(), 0);

        // Randomized run against the model.
        do_reset();
        model_step(7'b1000000);
        for (int cyc = 0; cyc < 4000; cyc++) begin
            logic [6:0] in;
            int rdy_pct;
            check($sformatf("random[%0d]", cyc), dut_out(), model_out());
            rdy_pct = ((cyc / 500) % 2 == 1) ? 4 : 70;
            in[6] = ($urandom_range(99) < 1);
            in[5] = ($urandom_range(99) < rdy_pct);
            in[4] = ($urandom_range(99) < 40);
            in[3] = ($urandom_range(99) < 8);
            in[2] = ($urandom_range(99) < 15);
            in[1] = ($urandom_range(99) < 15);
            in[0] = ($urandom_range(99) < 10);
            drive(in);
            model_step(in);
            @(negedge CLK);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
